// File: rtl/rv32v_types_pkg.sv
// Shared types for the vector ALU sequencer: FSM states, lane op encoding, default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32v_types_pkg;

    localparam int LANES_DEF = 4;   // elements per group, one SEW=32 element per lane
    localparam int VLMAX_DEF = 32;  // maximum elements per instruction

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } vseq_state_t;

    // VFU_NONE must stay at zero: an all-zero vexec_t means "no operation".
    typedef enum logic [1:0] {
        VFU_NONE = 2'd0,
        VFU_ALU  = 2'd1
    } vfu_t;

    typedef enum logic [2:0] {
        VALU_ADD = 3'd0,
        VALU_SUB = 3'd1,
        VALU_AND = 3'd2,
        VALU_OR  = 3'd3,
        VALU_XOR = 3'd4
    } valu_op_t;

    typedef struct packed {
        vfu_t     vfu;
        valu_op_t valuop;
    } vexec_t;

endpackage

// File: rtl/rv32v_seq_lane_en.sv
// Per-lane write enables for one element group: tail cut at vl, then v0 masking when vm=0.
// Latency: combinational.
// Backpressure: none.
//
// Ports: grp (group index), vl (active length, already clamped), vm (1=unmasked),
//        v0_bits (v0 mask bits of this group), lane_en (resulting enables).
module rv32v_seq_lane_en
    import rv32v_types_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int VL_W  = 6,
    parameter int GRP_W = 3
) (
    input  logic [GRP_W-1:0] grp,
    input  logic [VL_W-1:0]  vl,
    input  logic             vm,
    input  logic [LANES-1:0] v0_bits,
    output logic [LANES-1:0] lane_en
);

    // One extra bit so grp*LANES+i never wraps before the unsigned compare.
    logic [VL_W:0] base;
    assign base = (VL_W+1)'(grp) * (VL_W+1)'(LANES);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [VL_W:0] elem;
        assign elem       = base + (VL_W+1)'(i);
        assign lane_en[i] = (elem < {1'b0, vl}) & (vm | v0_bits[i]);
    end

endmodule

// File: rtl/rv32v_vfu_seq.sv
// Sequences one vector ALU instruction over element groups: RF read, lane exec, masked writeback.
// Latency: 3 cycles/group with wb_ready=1; done pulses 3*ceil(vl/LANES)+2 cycles after issue.
// Backpressure: issue_ready only in IDLE; wb_valid/wb_data/wb_lane_en/wb_grp held until wb_ready.
//
// Ports: CLK/RST (sync active-high); issue_* instruction in; rf_rd_* group read request,
//        rf_vs1/vs2_data + rf_v0_bits returned one cycle later; vfu_* drive to the external
//        lanes, vfu_res combinational lane results; wb_* group writeback; busy; done pulse.
// Option: RV32V_SEQ_MASK_SKIP_EN skips the WB of groups whose lane enables are all zero.
module rv32v_vfu_seq
    import rv32v_types_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int VLMAX = VLMAX_DEF,
    localparam int VL_W  = $clog2(VLMAX + 1),
    localparam int GRP_W = $clog2(VLMAX / LANES)
) (
    input  logic                  CLK,
    input  logic                  RST,
    // issue
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  vexec_t                issue_vop,
    input  logic [VL_W-1:0]       issue_vl,
    input  logic                  issue_vm,
    input  logic [4:0]            issue_vs1,
    input  logic [4:0]            issue_vs2,
    input  logic [4:0]            issue_vd,
    // vector RF read
    output logic                  rf_rd_en,
    output logic [4:0]            rf_rd_vs1,
    output logic [4:0]            rf_rd_vs2,
    output logic [GRP_W-1:0]      rf_rd_grp,
    input  logic [LANES*32-1:0]   rf_vs1_data,
    input  logic [LANES*32-1:0]   rf_vs2_data,
    input  logic [LANES-1:0]      rf_v0_bits,
    // lanes
    output vexec_t                vfu_vop,
    output logic [LANES*32-1:0]   vfu_opA,
    output logic [LANES*32-1:0]   vfu_opB,
    output logic [LANES-1:0]      vfu_mask,
    input  logic [LANES*32-1:0]   vfu_res,
    // writeback
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [4:0]            wb_vd,
    output logic [GRP_W-1:0]      wb_grp,
    output logic [LANES*32-1:0]   wb_data,
    output logic [LANES-1:0]      wb_lane_en,
    // status
    output logic                  busy,
    output logic                  done
);

    vseq_state_t           state_q, state_d;
    vexec_t                vop_q;
    logic [VL_W-1:0]       vl_q;
    logic                  vm_q;
    logic [4:0]            vs1_q, vs2_q, vd_q;
    logic [GRP_W-1:0]      grp_q;
    logic [LANES*32-1:0]   wb_data_q;
    logic [LANES-1:0]      wb_en_q;
    logic                  done_q;

    logic [LANES-1:0]      lane_en;
    logic [VL_W:0]         grp_end;
    logic                  last_grp;
    logic                  grp_adv;
    logic                  issue_fire;
    logic [VL_W-1:0]       vl_clamped;

    assign issue_fire = (state_q == IDLE) & issue_valid;
    assign vl_clamped = (issue_vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : issue_vl;

    // Last group once (grp+1)*LANES covers vl; widened so the product cannot wrap.
    assign grp_end  = ((VL_W+1)'(grp_q) + (VL_W+1)'(1)) * (VL_W+1)'(LANES);
    assign last_grp = (grp_end >= {1'b0, vl_q});

    rv32v_seq_lane_en #(
        .LANES (LANES),
        .VL_W  (VL_W),
        .GRP_W (GRP_W)
    ) u_lane_en (
        .grp     (grp_q),
        .vl      (vl_q),
        .vm      (vm_q),
        .v0_bits (rf_v0_bits),
        .lane_en (lane_en)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grp_adv = 1'b0;
        case (state_q)
            IDLE: begin
                // vl=0 retires without touching the RF or the write port.
                if (issue_valid) begin
                    state_d = (issue_vl == '0) ? DONE : READ;
                end
            end
            READ: state_d = EXEC;
            EXEC: begin
`ifdef RV32V_SEQ_MASK_SKIP_EN
                if (lane_en == '0) begin
                    state_d = last_grp ? DONE : READ;
                    grp_adv = ~last_grp;
                end else begin
                    state_d = WB;
                end
`else
                state_d = WB;
`endif
            end
            WB: begin
                if (wb_ready) begin
                    state_d = last_grp ? DONE : READ;
                    grp_adv = ~last_grp;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vop_q     <= '0;
            vl_q      <= '0;
            vm_q      <= 1'b0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            grp_q     <= '0;
            wb_data_q <= '0;
            wb_en_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            // done is registered off the DONE state, so it lands the cycle after DONE.
            done_q <= (state_q == DONE);
            if (issue_fire) begin
                vop_q <= issue_vop;
                vl_q  <= vl_clamped;
                vm_q  <= issue_vm;
                vs1_q <= issue_vs1;
                vs2_q <= issue_vs2;
                vd_q  <= issue_vd;
                grp_q <= '0;
            end else if (grp_adv) begin
                grp_q <= grp_q + GRP_W'(1);
            end
            if (state_q == EXEC) begin
                wb_data_q <= vfu_res;
                wb_en_q   <= lane_en;
            end
        end
    end

    assign issue_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rf_rd_en    = (state_q == READ);
    assign rf_rd_vs1   = vs1_q;
    assign rf_rd_vs2   = vs2_q;
    assign rf_rd_grp   = grp_q;

    // RF data is only valid in EXEC; outside it the lanes see a zero op and operands.
    assign vfu_vop  = (state_q == EXEC) ? vop_q       : '0;
    assign vfu_opA  = (state_q == EXEC) ? rf_vs2_data : '0;
    assign vfu_opB  = (state_q == EXEC) ? rf_vs1_data : '0;
    assign vfu_mask = (state_q == EXEC) ? lane_en     : '0;

    assign wb_valid   = (state_q == WB);
    assign wb_vd      = vd_q;
    assign wb_grp     = grp_q;
    assign wb_data    = wb_data_q;
    assign wb_lane_en = wb_en_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rv32v_vfu_seq.sv
`timescale 1ns/1ps
module tb_rv32v_vfu_seq;
    import rv32v_types_pkg::*;

    localparam int LANES = 4;
    localparam int VLMAX = 32;
    localparam int VL_W  = 6;
    localparam int GRP_W = 3;
    localparam int NGRP  = VLMAX / LANES;

    logic                CLK = 1'b0;
    logic                RST;
    logic                issue_valid, issue_ready, issue_vm;
    vexec_t              issue_vop;
    logic [VL_W-1:0]     issue_vl;
    logic [4:0]          issue_vs1, issue_vs2, issue_vd;
    logic                rf_rd_en;
    logic [4:0]          rf_rd_vs1, rf_rd_vs2;
    logic [GRP_W-1:0]    rf_rd_grp;
    logic [LANES*32-1:0] rf_vs1_data = '0;
    logic [LANES*32-1:0] rf_vs2_data = '0;
    logic [LANES-1:0]    rf_v0_bits  = '0;
    vexec_t              vfu_vop;
    logic [LANES*32-1:0] vfu_opA, vfu_opB, vfu_res;
    logic [LANES-1:0]    vfu_mask;
    logic                wb_valid, wb_ready;
    logic [4:0]          wb_vd;
    logic [GRP_W-1:0]    wb_grp;
    logic [LANES*32-1:0] wb_data;
    logic [LANES-1:0]    wb_lane_en;
    logic                busy, done;

    always #5 CLK = ~CLK;

    rv32v_vfu_seq #(.LANES(LANES), .VLMAX(VLMAX)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_vop(issue_vop),
        .issue_vl(issue_vl), .issue_vm(issue_vm), .issue_vs1(issue_vs1),
        .issue_vs2(issue_vs2), .issue_vd(issue_vd),
        .rf_rd_en(rf_rd_en), .rf_rd_vs1(rf_rd_vs1), .rf_rd_vs2(rf_rd_vs2), .rf_rd_grp(rf_rd_grp),
        .rf_vs1_data(rf_vs1_data), .rf_vs2_data(rf_vs2_data), .rf_v0_bits(rf_v0_bits),
        .vfu_vop(vfu_vop), .vfu_opA(vfu_opA), .vfu_opB(vfu_opB), .vfu_mask(vfu_mask),
        .vfu_res(vfu_res),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_vd(wb_vd), .wb_grp(wb_grp),
        .wb_data(wb_data), .wb_lane_en(wb_lane_en),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [GRP_W-1:0]    grp;
        logic [4:0]          vd;
        logic [LANES-1:0]    en;
        logic [LANES*32-1:0] data;
    } wb_exp_t;

    wb_exp_t          wb_q[$];
    int               done_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc     = 0;
    int               rd_seen = 0;
    int               wb_seen = 0;
    int               stall_left = 0;
    logic [31:0]      rf_mem [32][VLMAX];
    logic [LANES-1:0] v0_mem [NGRP];
    logic [4:0]       cur_vs1 = '0;
    logic [4:0]       cur_vs2 = '0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_op(input valu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            VALU_ADD: return a + b;
            VALU_SUB: return a - b;
            VALU_AND: return a & b;
            VALU_OR:  return a | b;
            VALU_XOR: return a ^ b;
            default:  return '0;
        endcase
    endfunction

    // External lanes: combinational, one element per lane.
    always_comb begin
        vfu_res = '0;
        for (int i = 0; i < LANES; i++)
            vfu_res[i*32 +: 32] = lane_op(vfu_vop.valuop, vfu_opA[i*32 +: 32], vfu_opB[i*32 +: 32]);
    end

    // Vector RF: group data returns the cycle after the read strobe.
    always @(posedge CLK) begin
        if (rf_rd_en) begin
            for (int i = 0; i < LANES; i++) begin
                rf_vs1_data[i*32 +: 32] <= rf_mem[rf_rd_vs1][int'(rf_rd_grp)*LANES + i];
                rf_vs2_data[i*32 +: 32] <= rf_mem[rf_rd_vs2][int'(rf_rd_grp)*LANES + i];
            end
            rf_v0_bits <= v0_mem[rf_rd_grp];
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: drives wb_ready stalls, checks WB groups and done timing against the scoreboard.
    initial begin
        wb_ready = 1'b1;
        forever begin
            @(negedge CLK);
            if (RST) begin
                wb_ready = 1'b1;
                continue;
            end
            if (wb_valid && stall_left > 0) begin
                wb_ready = 1'b0;
                stall_left--;
            end else begin
                wb_ready = 1'b1;
            end
            if (rf_rd_en) begin
                rd_seen++;
                chk("rd_vs1", 128'(rf_rd_vs1), 128'(cur_vs1));
                chk("rd_vs2", 128'(rf_rd_vs2), 128'(cur_vs2));
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 128'(wb_valid), 128'(0));
                end else begin
                    chk("wb_grp",  128'(wb_grp),     128'(wb_q[0].grp));
                    chk("wb_vd",   128'(wb_vd),      128'(wb_q[0].vd));
                    chk("wb_en",   128'(wb_lane_en), 128'(wb_q[0].en));
                    chk("wb_data", wb_data,          wb_q[0].data);
                    if (wb_ready) begin
                        void'(wb_q.pop_front());
                        wb_seen++;
                    end
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", 128'(done), 128'(0));
                else                    chk("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
            end
        end
    end

    task automatic wait_issue_ready();
        int t;
        t = 0;
        while (!issue_ready && t < 100) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("issue_ready", 128'(issue_ready), 128'(1));
    endtask

    task automatic run_op(input valu_op_t op, input int vl, input logic vm,
                          input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                          input int stall);
        int vle, ngrp, nwb, skipped, h, rd0, wb0, e, t;
        wb_exp_t x;
        wait_issue_ready();
        cur_vs1 = vs1;
        cur_vs2 = vs2;
        stall_left = stall;
        rd0 = rd_seen;
        wb0 = wb_seen;
        issue_vop   = '{vfu: VFU_ALU, valuop: op};
        issue_vl    = VL_W'(vl);
        issue_vm    = vm;
        issue_vs1   = vs1;
        issue_vs2   = vs2;
        issue_vd    = vd;
        issue_valid = 1'b1;
        h = cyc;
        vle = (vl > VLMAX) ? VLMAX : vl;
        ngrp = (vle + LANES - 1) / LANES;
        nwb = 0;
        skipped = 0;
        for (int g = 0; g < ngrp; g++) begin
            x.grp = GRP_W'(g);
            x.vd  = vd;
            x.en  = '0;
            x.data = '0;
            for (int i = 0; i < LANES; i++) begin
                e = g * LANES + i;
                x.en[i] = (e < vle) && (vm || v0_mem[g][i]);
                x.data[i*32 +: 32] = lane_op(op, rf_mem[vs2][e], rf_mem[vs1][e]);
            end
`ifdef RV32V_SEQ_MASK_SKIP_EN
            if (x.en == '0) begin
                skipped++;
                continue;
            end
`endif
            wb_q.push_back(x);
            nwb++;
        end
        done_q.push_back(h + 3 * ngrp + 2 + stall - skipped);
        @(posedge CLK); #1;
        issue_valid = 1'b0;
        t = 0;
        while (done_q.size() != 0 && t < 400) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("done_seen", 128'(done_q.size()), 128'(0));
        chk("rd_count",  128'(rd_seen - rd0), 128'(ngrp));
        chk("wb_count",  128'(wb_seen - wb0), 128'(nwb));
        chk("wb_drain",  128'(wb_q.size()),   128'(0));
        done_q.delete();
        wb_q.delete();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_issue_ready"}, 128'(issue_ready), 128'(1));
        chk({tag, "_busy"},        128'(busy),        128'(0));
        chk({tag, "_wb_valid"},    128'(wb_valid),    128'(0));
        chk({tag, "_rf_rd_en"},    128'(rf_rd_en),    128'(0));
        chk({tag, "_done"},        128'(done),        128'(0));
    endtask

    initial begin
        int t;
        RST = 1'b1;
        issue_valid = 1'b0;
        issue_vop = '0;
        issue_vl = '0;
        issue_vm = 1'b1;
        issue_vs1 = '0;
        issue_vs2 = '0;
        issue_vd = '0;
        for (int r = 0; r < 32; r++)
            for (int e = 0; e < VLMAX; e++)
                rf_mem[r][e] = $urandom;
        for (int g = 0; g < NGRP; g++) v0_mem[g] = '0;

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk_idle("rst");
        chk("rst_wb_lane_en", 128'(wb_lane_en), 128'(0));
        chk("rst_wb_data",    wb_data,          128'(0));
        chk("rst_vfu_vop",    128'(vfu_vop),    128'(0));
        chk("rst_vfu_mask",   128'(vfu_mask),   128'(0));
        chk("rst_rd_grp",     128'(rf_rd_grp),  128'(0));

        // Full groups, unmasked.
        run_op(VALU_ADD, 8, 1'b1, 5'd3, 5'd4, 5'd5, 0);
        // Tail in the second group; lane 0 of group 1 is 10-3.
        rf_mem[2][4] = 32'd10;
        rf_mem[1][4] = 32'd3;
        run_op(VALU_SUB, 5, 1'b1, 5'd1, 5'd2, 5'd9, 0);
        // Masked by v0, then an all-masked group.
        v0_mem[0] = 4'b1010;
        run_op(VALU_AND, 4, 1'b0, 5'd6, 5'd7, 5'd8, 0);
        v0_mem[0] = 4'b0000;
        run_op(VALU_OR, 4, 1'b0, 5'd10, 5'd11, 5'd12, 0);
        // Zero length.
        run_op(VALU_ADD, 0, 1'b1, 5'd13, 5'd14, 5'd15, 0);
        // Writeback stall of five cycles.
        run_op(VALU_XOR, 4, 1'b1, 5'd16, 5'd17, 5'd18, 5);
        // Over-length vl with random v0 masks and a mid-instruction stall.
        for (int g = 0; g < NGRP; g++) v0_mem[g] = LANES'($urandom);
        run_op(VALU_SUB, 40, 1'b0, 5'd19, 5'd20, 5'd21, 2);
        run_op(VALU_ADD, 31, 1'b1, 5'd22, 5'd23, 5'd24, 0);

        // Reset held for two cycles while a group waits in WB.
        wait_issue_ready();
        cur_vs1 = 5'd25;
        cur_vs2 = 5'd26;
        stall_left = 20;
        issue_vop = '{vfu: VFU_ALU, valuop: VALU_ADD};
        issue_vl = VL_W'(8);
        issue_vm = 1'b1;
        issue_vs1 = 5'd25;
        issue_vs2 = 5'd26;
        issue_vd = 5'd27;
        issue_valid = 1'b1;
        @(posedge CLK); #1;
        issue_valid = 1'b0;
        t = 0;
        while (!wb_valid && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("pre_rst_wb_valid", 128'(wb_valid), 128'(1));
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        stall_left = 0;
        wb_q.delete();
        done_q.delete();
        chk_idle("midrst");
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            chk("midrst_no_done", 128'(done), 128'(0));
        end

        // Recovery after reset.
        run_op(VALU_XOR, 3, 1'b1, 5'd28, 5'd29, 5'd30, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
